// File: rtl/hls_macc_mul_32s_bkb.sv
// Pipelined signed multiplier: operand register stage followed by product stages.
// Throughput of one pair per enabled cycle; dout is the last product register.
module hls_macc_mul_32s_bkb #(
  parameter ID         = 1,
  parameter NUM_STAGE  = 2,
  parameter din0_WIDTH = 32,
  parameter din1_WIDTH = 32,
  parameter dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int PROD_STAGES = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam bit CFG_BAD = (NUM_STAGE < 1) || (din0_WIDTH < 1) || (din1_WIDTH < 1) ||
                           (dout_WIDTH < 1) || (ID < 0);

  if (CFG_BAD) begin : g_cfg_check
    $error("hls_macc_mul_32s_bkb: illegal parameterisation (NUM_STAGE must be >= 1)");
  end

  // Only the low dout_WIDTH bits of the product are kept, and those depend only on
  // the low dout_WIDTH bits of each sign-extended operand.
  function automatic logic [dout_WIDTH-1:0] sext0(input logic [din0_WIDTH-1:0] v);
    logic [dout_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < dout_WIDTH; i++) begin
      r[i] = v[(i < din0_WIDTH) ? i : din0_WIDTH - 1];
    end
    return r;
  endfunction

  function automatic logic [dout_WIDTH-1:0] sext1(input logic [din1_WIDTH-1:0] v);
    logic [dout_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < dout_WIDTH; i++) begin
      r[i] = v[(i < din1_WIDTH) ? i : din1_WIDTH - 1];
    end
    return r;
  endfunction

  logic [din0_WIDTH-1:0] mul_a_s;
  logic [din1_WIDTH-1:0] mul_b_s;
  logic [dout_WIDTH-1:0] prod_s;
  logic [dout_WIDTH-1:0] prod_r [PROD_STAGES];

  if (NUM_STAGE > 1) begin : g_in_reg
    logic [din0_WIDTH-1:0] a_r;
    logic [din1_WIDTH-1:0] b_r;

    // Stage 1: capture the operand pair.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        a_r <= '0;
        b_r <= '0;
      end else if (ce) begin
        a_r <= din0;
        b_r <= din1;
      end
    end

    assign mul_a_s = a_r;
    assign mul_b_s = b_r;
  end else begin : g_in_direct
    assign mul_a_s = din0;
    assign mul_b_s = din1;
  end

  assign prod_s = sext0(mul_a_s) * sext1(mul_b_s);

  // Product stages: shift the product toward dout while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROD_STAGES; i++) begin
        prod_r[i] <= '0;
      end
    end else if (ce) begin
      prod_r[0] <= prod_s;
      for (int i = 1; i < PROD_STAGES; i++) begin
        prod_r[i] <= prod_r[i-1];
      end
    end
  end

  assign dout = prod_r[PROD_STAGES-1];

endmodule

// File: tb/tb_hls_macc_mul_32s_bkb.sv
// Self-checking bench: three pipeline depths (1, 2, 4) share stimulus and are
// compared against a queue of accepted products.
module tb_hls_macc_mul_32s_bkb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] din0 = 32'd0;
  logic [31:0] din1 = 32'd0;
  logic [31:0] dout1, dout2, dout4;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] acc[$];

  hls_macc_mul_32s_bkb #(.ID(1), .NUM_STAGE(1), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(32))
    dut1 (.clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1), .dout(dout1));
  hls_macc_mul_32s_bkb dut2 (.clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1), .dout(dout2));
  hls_macc_mul_32s_bkb #(.ID(3), .NUM_STAGE(4), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(32))
    dut4 (.clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1), .dout(dout4));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[31:0];
  endfunction

  // Value dout should show for a pipeline of the given depth after the accepted pairs so far.
  function automatic logic [31:0] expect_dout(input int depth);
    if (acc.size() < depth) return 32'd0;
    return acc[acc.size() - depth];
  endfunction

  task automatic cycle(input logic c, input logic [31:0] a, input logic [31:0] b);
    ce = c;
    din0 = a;
    din1 = b;
    @(posedge clk);
    #1;
    if (c && reset) acc.push_back(ref_prod(a, b));
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    compared++;
    if ({dout1, dout2, dout4} !== 96'd0) begin
      mismatched++;
      $display("FAIL reset_initial: got %h %h %h, want 0", dout1, dout2, dout4);
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, $urandom);
    compared++;
    if ({dout1, dout2, dout4} !== 96'd0) begin
      mismatched++;
      $display("FAIL reset_held_clocked: got %h %h %h, want 0", dout1, dout2, dout4);
    end
    reset = 1'b1;
    acc.delete();
  endtask

  task automatic test_latency;
    cycle(1'b1, 32'd3, 32'd4);
    compared++;
    if (dout2 !== 32'd0 || dout1 !== 32'd12 || dout4 !== 32'd0) begin
      mismatched++;
      $display("FAIL latency_edge0: got d1=%h d2=%h d4=%h, want 0000000c 00000000 00000000", dout1, dout2, dout4);
    end
    cycle(1'b1, 32'd0, 32'd0);
    compared++;
    if (dout2 !== 32'd12 || dout1 !== 32'd0 || dout4 !== 32'd0) begin
      mismatched++;
      $display("FAIL latency_edge1: got d1=%h d2=%h d4=%h, want 00000000 0000000c 00000000", dout1, dout2, dout4);
    end
    cycle(1'b1, 32'd0, 32'd0);
    compared++;
    if (dout4 !== 32'd0) begin
      mismatched++;
      $display("FAIL latency4_edge2: got %h, want 00000000", dout4);
    end
    cycle(1'b1, 32'd0, 32'd0);
    compared++;
    if (dout4 !== 32'd12 || dout2 !== 32'd0) begin
      mismatched++;
      $display("FAIL latency4_edge3: got d4=%h d2=%h, want 0000000c 00000000", dout4, dout2);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b1, 32'hFFFF_FFFB, 32'd7);
    cycle(1'b1, 32'h7FFF_FFFF, 32'd2);
    compared++;
    if (dout2 !== 32'hFFFF_FFDD) begin
      mismatched++;
      $display("FAIL b2b_first: got %h, want ffffffdd", dout2);
    end
    cycle(1'b1, 32'h0001_0000, 32'h0001_0000);
    compared++;
    if (dout2 !== 32'hFFFF_FFFE) begin
      mismatched++;
      $display("FAIL b2b_second: got %h, want fffffffe", dout2);
    end
    cycle(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    compared++;
    if (dout2 !== 32'h0000_0000 || dout1 !== 32'h8000_0000) begin
      mismatched++;
      $display("FAIL b2b_third: got d2=%h d1=%h, want 00000000 80000000", dout2, dout1);
    end
    cycle(1'b1, $urandom, $urandom);
    compared++;
    if (dout2 !== 32'h8000_0000) begin
      mismatched++;
      $display("FAIL overflow_trunc: got %h, want 80000000", dout2);
    end
    compared++;
    if (dout4 !== expect_dout(4)) begin
      mismatched++;
      $display("FAIL b2b_depth4: got %h, want %h", dout4, expect_dout(4));
    end
  endtask

  task automatic test_stall;
    logic [31:0] held2, held4;
    cycle(1'b1, 32'd6, 32'd7);
    held2 = expect_dout(2);
    held4 = expect_dout(4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, $urandom, $urandom);
      compared++;
      if (dout2 !== held2 || dout4 !== held4) begin
        mismatched++;
        $display("FAIL stall_hold_%0d: got d2=%h d4=%h, want %h %h", i, dout2, dout4, held2, held4);
      end
    end
    cycle(1'b1, $urandom, $urandom);
    compared++;
    if (dout2 !== 32'd42) begin
      mismatched++;
      $display("FAIL stall_resume: got %h, want 0000002a", dout2);
    end
    compared++;
    if (dout1 !== expect_dout(1) || dout4 !== expect_dout(4)) begin
      mismatched++;
      $display("FAIL stall_resume_other: got d1=%h d4=%h, want %h %h", dout1, dout4, expect_dout(1), expect_dout(4));
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom | 32'd1, $urandom | 32'd1);
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if ({dout1, dout2, dout4} !== 96'd0) begin
      mismatched++;
      $display("FAIL reset_async: got %h %h %h, want 0", dout1, dout2, dout4);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    acc.delete();
    cycle(1'b1, 32'd2, 32'd9);
    compared++;
    if (dout1 !== 32'd18 || dout2 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_resume_edge0: got d1=%h d2=%h, want 00000012 00000000", dout1, dout2);
    end
    cycle(1'b1, 32'd0, 32'd0);
    compared++;
    if (dout2 !== 32'd18 || dout4 !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_resume_edge1: got d2=%h d4=%h, want 00000012 00000000", dout2, dout4);
    end
    cycle(1'b1, 32'd0, 32'd0);
    cycle(1'b1, 32'd0, 32'd0);
    compared++;
    if (dout4 !== 32'd18) begin
      mismatched++;
      $display("FAIL reset_resume_depth4: got %h, want 00000012", dout4);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        c;
    for (int n = 0; n < 300; n++) begin
      c = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'h8000_0000; b = $urandom; end
        2: begin a = $urandom_range(0, 255) - 128; b = $urandom_range(0, 255) - 128; end
        default: begin a = 32'h7FFF_FFFF; b = 32'hFFFF_FFFF - $urandom_range(0, 3); end
      endcase
      cycle(c, a, b);
      compared++;
      if (dout1 !== expect_dout(1) || dout2 !== expect_dout(2) || dout4 !== expect_dout(4)) begin
        mismatched++;
        $display("FAIL random_%0d: got %h %h %h, want %h %h %h", n, dout1, dout2, dout4,
                 expect_dout(1), expect_dout(2), expect_dout(4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hls_macc_mul_32s_bkb.md
HLS_MACC_MUL_32S_BKB -- requirements
Module: hls_macc_mul_32s_bkb

Interface
REQ-001 SHALL have parameter ID, default 1: instance tag only, no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 2: pipeline depth in clock cycles, legal range >= 1.
REQ-003 SHALL have parameter din0_WIDTH, default 32: width of operand 0.
REQ-004 SHALL have parameter din1_WIDTH, default 32: width of operand 1.
REQ-005 SHALL have parameter dout_WIDTH, default 32: width of the product output.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ce, input, 1 bit: clock enable; 1 advances the pipeline, 0 holds it.
REQ-009 SHALL have port din0, input, din0_WIDTH bits: signed two's-complement operand.
REQ-010 SHALL have port din1, input, din1_WIDTH bits: signed two's-complement operand.
REQ-011 SHALL have port dout, output, dout_WIDTH bits: registered signed product.

Function
REQ-012 SHALL compute the full signed product din0*din1, sign-extending each operand before multiplying.
REQ-013 SHALL truncate the product to its low dout_WIDTH bits; if dout_WIDTH exceeds din0_WIDTH+din1_WIDTH, SHALL sign-extend it instead.
REQ-014 SHALL register din0/din1 in stage 1; stages 2..NUM_STAGE SHALL register the product; dout SHALL be driven directly from the last stage register.
REQ-015 SHALL, when NUM_STAGE=1, register the product of the unregistered inputs once.
REQ-016 SHALL have a latency of exactly NUM_STAGE rising edges with ce=1: operands sampled at edge k appear on dout after edge k+NUM_STAGE-1.
REQ-017 SHALL accept one new operand pair every cycle with ce=1 (initiation interval 1), with no bubbles.
REQ-018 SHALL, when ce=0 at an edge, leave every pipeline register, and therefore dout, unchanged; no data is lost or duplicated across stalls.
REQ-019 SHALL have no handshake and no valid flag; the caller tracks latency.
REQ-020 SHALL be free of combinational paths from din0, din1 or ce to dout.
REQ-021 SHALL treat X or ignored parameter values as a misconfiguration; NUM_STAGE<1 SHALL be flagged by an elaboration-time check.

Reset
REQ-022 SHALL, while reset=0, asynchronously clear all pipeline registers to 0 so that dout=0, independent of clk and ce.
REQ-023 SHALL discard in-flight products on reset deassertion (reset mid-operation); the first valid dout is NUM_STAGE ce-cycles after new operands are applied.
REQ-024 SHALL resume pipeline operation on the first rising edge after reset returns to 1.

Verification
REQ-025 With defaults, reset released, ce=1, din0=3, din1=4 at edge 0 -> dout=12 (0x0000000C) after edge 1, with 0 before that.
REQ-026 Back-to-back pairs (-5,7), (0x7FFFFFFF,2), (0x00010000,0x00010000) on consecutive edges -> dout=0xFFFFFFDD, 0xFFFFFFFE, 0x00000000 on consecutive cycles.
REQ-027 Pair (6,7) applied, then ce=0 for 3 cycles with other operands on din -> dout holds its previous value; when ce=1 is restored, 42 emerges with no loss.
REQ-028 Pair (0x80000000,-1) -> dout=0x80000000 (truncated overflow).
REQ-029 With the pipeline full of non-zero products, pulse reset=0 between clock edges -> dout=0 immediately; after release, pair (2,9) -> 18 after NUM_STAGE edges.
REQ-030 Repeat REQ-025 with NUM_STAGE=1 and NUM_STAGE=4 -> latency of 1 and 4 edges respectively.
